decode_scoreboard_ctrl: RTL

Issue controller for the decode stage. Tracks in-flight writes to the 32-entry register file with per-register pending counters. Stalls decode on read-after-write hazards and on counter saturation, and sequences the wrong-path flush after a taken branch. Sits beside `stage_2`: it consumes decoded register numbers, the branch-unit decision and the writeback port (`i_reg_op`/`i_w_rd_num`), and drives issue/stall/flush to the fetch and decode pipeline registers.

---
 rtl/decode_scoreboard_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/decode_scoreboard_ctrl.sv
// Decode-stage issue controller: per-register pending-write scoreboard,
// RAW/structural stall generation and wrong-path flush sequencing after taken branches.
module decode_scoreboard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter bit          WB_BYPASS    = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_dec_valid,
    input  logic [4:0]  i_rs1_num,
    input  logic [4:0]  i_rs2_num,
    input  logic        i_rs1_used,
    input  logic        i_rs2_used,
    input  logic [4:0]  i_rd_num,
    input  logic        i_rd_wen,
    input  logic        i_b_taken,
    input  logic        i_reg_op,
    input  logic [4:0]  i_w_rd_num,
    output logic        o_issue,
    output logic        o_stall,
    output logic        o_redirect,
    output logic        o_flush,
    output logic [31:0] o_busy,
    output logic        o_err
);

    localparam int unsigned NREG = 32;
    localparam int unsigned CW   = 2;
    localparam int unsigned RW   = 5;
    localparam int unsigned FW   = 3;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t          state_q;
    logic [FW-1:0]   fcnt_q;
    logic [CW-1:0]   cnt_q [NREG];
    logic            err_q;

    logic [CW-1:0]   rs1_cnt;
    logic [CW-1:0]   rs2_cnt;
    logic [CW-1:0]   rd_cnt;
    logic [CW-1:0]   wb_cnt;
    logic            rs1_byp;
    logic            rs2_byp;
    logic            rs1_haz;
    logic            rs2_haz;
    logic            struct_haz;
    logic            hazard;
    logic            inc_en;
    logic            dec_en;
    logic            err_hit;

    // Hazard detection against the registered pending counts
    always_comb begin
        rs1_cnt    = cnt_q[i_rs1_num];
        rs2_cnt    = cnt_q[i_rs2_num];
        rd_cnt     = cnt_q[i_rd_num];
        wb_cnt     = cnt_q[i_w_rd_num];
        rs1_byp    = WB_BYPASS && (rs1_cnt == CW'(1)) && i_reg_op && (i_w_rd_num == i_rs1_num);
        rs2_byp    = WB_BYPASS && (rs2_cnt == CW'(1)) && i_reg_op && (i_w_rd_num == i_rs2_num);
        rs1_haz    = i_rs1_used && (rs1_cnt != '0) && !rs1_byp;
        rs2_haz    = i_rs2_used && (rs2_cnt != '0) && !rs2_byp;
        struct_haz = i_rd_wen && (i_rd_num != '0) && (rd_cnt == CW'(3));
        hazard     = rs1_haz || rs2_haz || struct_haz;
    end

    // Issue/stall/redirect are zero-latency; everything is quiet while in reset
    always_comb begin
        o_issue    = 1'b0;
        o_stall    = 1'b0;
        o_redirect = 1'b0;
        o_flush    = 1'b0;
        if (!i_rst) begin
            if (state_q == ST_RUN) begin
                o_issue    = i_dec_valid && !hazard;
                o_stall    = i_dec_valid && hazard;
                o_redirect = i_dec_valid && !hazard && i_b_taken;
            end else begin
                o_flush    = 1'b1;
            end
        end
    end

    always_comb begin
        inc_en  = o_issue && i_rd_wen && (i_rd_num != '0);
        dec_en  = i_reg_op && (i_w_rd_num != '0) && (wb_cnt != '0);
        err_hit = i_reg_op && (i_w_rd_num != '0) && (wb_cnt == '0);
    end

    // Flush sequencer: counter holds remaining wrong-path cycles, exit when it reaches 1
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_RUN;
            fcnt_q  <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (o_redirect) begin
                        state_q <= ST_FLUSH;
                        fcnt_q  <= FW'(FLUSH_CYCLES);
                    end
                end
                ST_FLUSH: begin
                    if (fcnt_q <= FW'(1)) begin
                        state_q <= ST_RUN;
                        fcnt_q  <= '0;
                    end else begin
                        fcnt_q  <= fcnt_q - FW'(1);
                    end
                end
            endcase
        end
    end

    // Pending counters; x0 stays zero, simultaneous inc/dec of one register cancel
    always_ff @(posedge i_clk) begin
        cnt_q[0] <= '0;
        if (i_rst) begin
            for (int unsigned i = 1; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int unsigned i = 1; i < NREG; i++) begin
                if (inc_en && (i_rd_num == RW'(i)) && !(dec_en && (i_w_rd_num == RW'(i)))) begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end else if (dec_en && (i_w_rd_num == RW'(i)) && !(inc_en && (i_rd_num == RW'(i)))) begin
                    cnt_q[i] <= cnt_q[i] - CW'(1);
                end
            end
            if (err_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        o_busy = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            o_busy[i] = (cnt_q[i] != '0);
        end
    end

    assign o_err = err_q;

endmodule
